// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_pkg
//  Description : Shared types, default rainbow palette and duty scaling
//                helper for the RGB PWM blocks.
//  Revision    : 1.0  initial release
// ============================================================================
package pwm_pkg;

    typedef enum logic {
        PH_RISE = 1'b0,
        PH_FALL = 1'b1
    } phase_e;

    // Entry 0 in the low bits: red, orange, yellow, green, blue, indigo, purple
    localparam logic [167:0] c_rainbow_palette =
        168'hA020F0_082E54_0000FF_00FF00_FFFF00_FF3C00_FF0000;

    // (val * (lvl + 1)) >> dw; lvl = MAX returns val, lvl = 0 returns 0
    function automatic logic [31:0] scale(
        input logic [31:0] val,
        input logic [31:0] lvl,
        input int unsigned dw
    );
        logic [63:0] prod;
        logic [63:0] shifted;
        prod    = {32'd0, val} * ({32'd0, lvl} + 64'd1);
        shifted = prod >> dw;
        return shifted[31:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_tick_gen
//  Description : Prescaler producing a tick every DIV enabled clocks, with a
//                synchronous clear.
//  Revision    : 1.0  initial release
// ============================================================================
module pwm_tick_gen #(
    parameter int unsigned DIV = 625000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int unsigned     c_cw   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(DIV - 1);

    logic [c_cw-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= (r_count == c_last) ? '0 : r_count + 1'b1;
        end
    end

    assign o_tick = i_en && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/pwm_color_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_color_sequencer
//  Description : Breathing rainbow sequencer over a writable palette, emitting
//                registered per-channel PWM duty words.
//  Revision    : 1.0  initial release
// ============================================================================
module pwm_color_sequencer
    import pwm_pkg::*;
#(
    parameter int unsigned               CH           = 3,
    parameter int unsigned               DW           = 8,
    parameter int unsigned               NCOLOR       = 7,
    parameter int unsigned               AW           = 3,
    parameter int unsigned               DIV          = 625000,
    parameter logic [NCOLOR*CH*DW-1:0]   PALETTE_INIT = c_rainbow_palette
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 mode,
    input  logic                 hold,
    input  logic                 next,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [CH*DW-1:0]     wr_data,
    output logic [CH*DW-1:0]     duty_out,
    output logic [AW-1:0]        color_idx,
    output logic                 phase,
    output logic                 color_done
);

    localparam logic [DW-1:0] c_max      = {DW{1'b1}};
    localparam logic [AW-1:0] c_last_idx = AW'(NCOLOR - 1);
    localparam logic [AW:0]   c_ncolor   = (AW + 1)'(NCOLOR);

    logic [CH*DW-1:0] r_pal [NCOLOR];

    phase_e           r_phase, w_phase_nxt;
    logic [DW-1:0]    r_level, w_level_nxt;
    logic [AW-1:0]    r_idx, w_idx_nxt, w_idx_inc;
    logic             r_done, w_done_nxt;
    logic             w_tick;
    logic             w_next_go;
    logic [DW-1:0]    w_disp;
    logic [CH*DW-1:0] w_cur;
    logic [CH*DW-1:0] w_duty;
    logic [CH*DW-1:0] r_duty;

    assign w_next_go = en & next;

    pwm_tick_gen #(
        .DIV    (DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (en),
        .i_clr  (w_next_go),
        .o_tick (w_tick)
    );

    // Palette writes are independent of en; out-of-range addresses are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCOLOR; k++) begin
                r_pal[k] <= PALETTE_INIT[k*CH*DW +: CH*DW];
            end
        end else if (wr_en && ({1'b0, wr_addr} < c_ncolor)) begin
            r_pal[wr_addr] <= wr_data;
        end
    end

    assign w_idx_inc = (r_idx == c_last_idx) ? '0 : r_idx + 1'b1;

    always_comb begin
        w_phase_nxt = r_phase;
        w_level_nxt = r_level;
        w_idx_nxt   = r_idx;
        w_done_nxt  = 1'b0;
        if (w_next_go) begin
            w_phase_nxt = PH_RISE;
            w_level_nxt = '0;
            w_idx_nxt   = w_idx_inc;
            w_done_nxt  = 1'b1;
        end else if (w_tick) begin
            case (r_phase)
                PH_RISE: begin
                    w_level_nxt = r_level + 1'b1;
                    if (w_level_nxt == c_max) begin
                        w_phase_nxt = PH_FALL;
                    end
                end
                PH_FALL: begin
                    w_level_nxt = r_level - 1'b1;
                    if (w_level_nxt == '0) begin
                        // Ramp restarts even when hold keeps the colour
                        w_phase_nxt = PH_RISE;
                        if (!hold) begin
                            w_idx_nxt  = w_idx_inc;
                            w_done_nxt = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign w_disp = mode ? c_max : r_level;
    assign w_cur  = r_pal[r_idx];

    for (genvar c = 0; c < CH; c++) begin : g_ch
        assign w_duty[c*DW +: DW] = DW'(scale(32'(w_cur[c*DW +: DW]), 32'(w_disp), DW));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= PH_RISE;
            r_level <= '0;
            r_idx   <= '0;
            r_done  <= 1'b0;
            r_duty  <= '0;
        end else begin
            r_phase <= w_phase_nxt;
            r_level <= w_level_nxt;
            r_idx   <= w_idx_nxt;
            r_done  <= w_done_nxt;
            r_duty  <= w_duty;
        end
    end

    assign duty_out   = r_duty;
    assign color_idx  = r_idx;
    assign phase      = r_phase;
    assign color_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pwm_color_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_color_sequencer
//  Description : Directed self-checking bench for pwm_color_sequencer, DIV=1.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pwm_color_sequencer;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        mode;
    logic        hold;
    logic        next;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [23:0] wr_data;
    logic [23:0] duty_out;
    logic [2:0]  color_idx;
    logic        phase;
    logic        color_done;

    int errors;
    int checks;
    int cyc;
    int pulses;
    int bad;

    pwm_color_sequencer #(
        .DIV        (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mode       (mode),
        .hold       (hold),
        .next       (next),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .duty_out   (duty_out),
        .color_idx  (color_idx),
        .phase      (phase),
        .color_done (color_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to the negedge following clock edge number 'target'
    task automatic run_to(input int target);
        while (cyc < target) begin
            @(negedge clk);
            cyc++;
            if (color_done === 1'b1) pulses++;
        end
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b1; en = 1'b0; mode = 1'b0; hold = 1'b0; next = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        errors = 0; checks = 0; cyc = 0; pulses = 0; bad = 0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_duty",  32'(duty_out),   32'h0);
        chk("rst_idx",   32'(color_idx),  32'h0);
        chk("rst_phase", 32'(phase),      32'h0);
        chk("rst_done",  32'(color_done), 32'h0);

        // Breathe on red: peak then boundary into orange
        rst_n = 1'b1; en = 1'b1;
        run_to(255);
        chk("t1_phase_fall", 32'(phase), 32'h1);
        chk("t1_idx0", 32'(color_idx), 32'h0);
        run_to(256);
        chk("t1_peak", 32'(duty_out), 32'hFF0000);
        run_to(509);
        chk("t1_done_pre", 32'(color_done), 32'h0);
        run_to(510);
        chk("t1_idx1", 32'(color_idx), 32'h1);
        chk("t1_done", 32'(color_done), 32'h1);
        chk("t1_rise", 32'(phase), 32'h0);
        run_to(511);
        chk("t1_duty_zero", 32'(duty_out), 32'h0);
        chk("t1_done_clr", 32'(color_done), 32'h0);
        chk("t1_pulses", 32'(pulses), 32'h1);

        // Orange at level 128
        run_to(639);
        chk("t2_lvl128", 32'(duty_out), 32'h801E00);

        // Steady yellow for a full colour period
        run_to(1020);
        chk("t3_idx2", 32'(color_idx), 32'h2);
        mode = 1'b1;
        for (int i = 0; i < 510; i++) begin
            @(negedge clk);
            cyc++;
            if (duty_out !== 24'hFFFF00) bad++;
        end
        chk("t3_steady", 32'(bad), 32'h0);
        run_to(1600);
        chk("t3_idx3", 32'(color_idx), 32'h3);
        mode = 1'b0;
        run_to(1601);
        chk("t3_breathe70", 32'(duty_out), 32'h004600);
        chk("t3_idx_keep", 32'(color_idx), 32'h3);
        chk("t3_phase_keep", 32'(phase), 32'h0);
        mode = 1'b1;
        run_to(1602);
        chk("t3_steady_again", 32'(duty_out), 32'h00FF00);
        mode = 1'b0;

        // Hold across the purple boundary, then wrap to red
        run_to(3500);
        chk("t4_idx6", 32'(color_idx), 32'h6);
        hold = 1'b1;
        pulses = 0;
        run_to(3571);
        chk("t4_hold_idx", 32'(color_idx), 32'h6);
        chk("t4_hold_nodone", 32'(pulses), 32'h0);
        chk("t4_hold_rise", 32'(phase), 32'h0);
        hold = 1'b0;
        run_to(4080);
        chk("t4_wrap_idx", 32'(color_idx), 32'h0);
        chk("t4_wrap_done", 32'(color_done), 32'h1);

        // next at level 100 in RISE
        run_to(4180);
        chk("t5_pre_rise", 32'(phase), 32'h0);
        next = 1'b1;
        run_to(4181);
        next = 1'b0;
        chk("t5_next_idx", 32'(color_idx), 32'h1);
        chk("t5_next_done", 32'(color_done), 32'h1);
        run_to(4182);
        chk("t5_next_duty0", 32'(duty_out), 32'h0);
        chk("t5_next_done_clr", 32'(color_done), 32'h0);

        // next on the final FALL tick advances exactly once
        run_to(4690);
        chk("t5_pre_fall", 32'(phase), 32'h1);
        chk("t5_pre_idx", 32'(color_idx), 32'h1);
        next = 1'b1;
        pulses = 0;
        run_to(4691);
        next = 1'b0;
        chk("t5_coinc_idx", 32'(color_idx), 32'h2);
        chk("t5_coinc_rise", 32'(phase), 32'h0);
        run_to(4692);
        chk("t5_coinc_once", 32'(pulses), 32'h1);

        // next while paused is ignored
        en = 1'b0;
        next = 1'b1;
        run_to(4693);
        next = 1'b0;
        chk("t5_pause_idx", 32'(color_idx), 32'h2);
        chk("t5_pause_done", 32'(color_done), 32'h0);
        en = 1'b1;

        // Palette write to the displayed entry
        mode = 1'b1;
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 24'h123456;
        run_to(4694);
        wr_en = 1'b0;
        chk("t6_pre_write", 32'(duty_out), 32'hFFFF00);
        run_to(4695);
        chk("t6_written", 32'(duty_out), 32'h123456);
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 24'hABCDEF;
        run_to(4696);
        wr_en = 1'b0;
        run_to(4697);
        chk("t6_addr7_ignored", 32'(duty_out), 32'h123456);

        // Asynchronous reset mid-ramp restores state and palette
        rst_n = 1'b0;
        #1;
        chk("t6_rst_idx", 32'(color_idx), 32'h0);
        chk("t6_rst_duty", 32'(duty_out), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        run_to(1);
        chk("t6_red_steady", 32'(duty_out), 32'hFF0000);
        next = 1'b1;
        run_to(3);
        next = 1'b0;
        chk("t6_idx2_again", 32'(color_idx), 32'h2);
        run_to(4);
        chk("t6_palette_restored", 32'(duty_out), 32'hFFFF00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
